// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Results are held in dedicated registers that only change on entry to DONE.
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DIVIDEND_W-1:0]   q_q, q_d;
    logic [DIVISOR_W-1:0]    d_q, d_d;
    logic [DIVISOR_W:0]      r_q, r_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DIVIDEND_W-1:0]   quot_q, quot_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic                    dbz_q, dbz_d;

    logic [DIVISOR_W:0]      r_shift_s;
    logic [DIVISOR_W+1:0]    trial_s;
    logic [DIVISOR_W:0]      r_next_s;
    logic [DIVIDEND_W-1:0]   q_next_s;

    // One restoring step: the extra top bit of trial_s is the borrow, i.e. the sign of T.
    assign r_shift_s = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    assign trial_s   = {1'b0, r_shift_s} - {2'b00, d_q};
    assign r_next_s  = trial_s[DIVISOR_W+1] ? r_shift_s : trial_s[DIVISOR_W:0];
    assign q_next_s  = {q_q[DIVIDEND_W-2:0], ~trial_s[DIVISOR_W+1]};

    // Next-state, datapath and result-register load logic.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    count_d = CNT_W'(DIVIDEND_W);
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                q_d     = q_next_s;
                r_d     = r_next_s;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    quot_d  = q_next_s;
                    rem_d   = r_next_s[DIVISOR_W-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, working and result registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a vector table plus hand sequences for
// back-to-back starts, ignored starts while busy, and reset mid-division.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] prev_q;
    logic [3:0] prev_r;
    logic       prev_dbz;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
    } vec_t;

    vec_t tbl[8];

    seq_divider dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One division from IDLE; samples on negedges, index 1 is the cycle after the accepting edge.
    task automatic run_one(input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic ed);
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat  = ed ? 1 : 9;
        lat      = -1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = ~a; divisor = ~b;
        if (!ed) begin
            check("hold_q", quotient, prev_q);
            check("hold_r", remainder, prev_r);
            check("hold_dbz", div_by_zero, prev_dbz);
        end
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy) busy_cnt++;
            if (done && lat < 0) begin
                lat = cyc;
                check("quotient", quotient, eq);
                check("remainder", remainder, er);
                check("div_by_zero", div_by_zero, ed);
            end
            if (!busy) break;
            @(negedge clk);
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
        check("idle_done_low", done, 0);
        prev_q = eq; prev_r = er; prev_dbz = ed;
    endtask

    initial begin
        int lat1;
        int lat2;
        int lat;

        tbl[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dbz: 1'b0};
        tbl[1] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, dbz: 1'b0};
        tbl[2] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dbz: 1'b0};
        tbl[3] = '{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5, dbz: 1'b0};
        tbl[4] = '{a: 8'd0,   b: 4'd3,  q: 8'd0,   r: 4'd0, dbz: 1'b0};
        tbl[5] = '{a: 8'd100, b: 4'd0,  q: 8'd255, r: 4'd0, dbz: 1'b1};
        tbl[6] = '{a: 8'd10,  b: 4'd3,  q: 8'd3,   r: 4'd1, dbz: 1'b0};
        tbl[7] = '{a: 8'd7,   b: 4'd2,  q: 8'd3,   r: 4'd1, dbz: 1'b0};

        reset_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        prev_q = 8'd0; prev_r = 4'd0; prev_dbz = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) run_one(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);

        // Back-to-back: start held high, second operands present from the cycle after the first accept.
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 4'd15;
        @(negedge clk);
        dividend = 8'd255; divisor = 4'd1;
        lat1 = -1; lat2 = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 10) check("b2b_gap_busy", busy, 0);
            if (done && lat1 < 0) begin
                lat1 = cyc;
                check("b2b_q1", quotient, 17);
                check("b2b_r1", remainder, 0);
            end else if (done && lat2 < 0 && cyc > lat1 + 1) begin
                lat2 = cyc;
                start = 1'b0;
                check("b2b_q2", quotient, 255);
                check("b2b_r2", remainder, 0);
            end
            if (lat2 > 0) break;
            @(negedge clk);
        end
        check("b2b_lat1", lat1, 9);
        check("b2b_lat2", lat2, 19);
        start = 1'b0;
        @(negedge clk);
        prev_q = 8'd255; prev_r = 4'd0; prev_dbz = 1'b0;

        // Start pulsed with new operands during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        check("run_hold_q", quotient, prev_q);
        lat = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 5) begin start = 1'b1; dividend = 8'd9; divisor = 4'd3; end
            if (cyc == 6) start = 1'b0;
            if (done && lat < 0) begin
                lat = cyc;
                check("ign_q", quotient, 28);
                check("ign_r", remainder, 4);
            end
            if (lat > 0) break;
            @(negedge clk);
        end
        check("ign_lat", lat, 9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ign_no_requeue", busy, 0);
        end

        // Reset mid-division: outputs clear at once and no done follows.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) reset_n = 1'b1;
            check("mid_rst_no_done", done, 0);
        end
        prev_q = 8'd0; prev_r = 4'd0; prev_dbz = 1'b0;
        run_one(8'd12, 4'd5, 8'd2, 4'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
